clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Power-up/restart sequencer driving clk_rst_gen: programs the 3 PLL dividers (e_core, p_core, sl),
//  waits for all PLL locks, then enables clocks and releases resets domain by domain.
//  Domain index: 0=e_core 1=p_core 2=cl 3=sl 4=pl. Runs on ref_clk_i, ahead of clk_rst_gen.
// PARAMETERS
//  NUM_DOM       5     number of clock/reset domains sequenced
//  SETTLE_CYC    16    cycles dividers are held stable before lock is checked (>=1)
//  LOCK_TIMEOUT  4096  max WAIT_LOCK cycles before error (>=1)
//  STEP_DLY      8     cycles between consecutive sequencing steps (>=1)
//  DEF_REF_DIV   4     reset value of every pll_ref_div_o lane
//  DEF_FB_DIV    48    reset value of every pll_fb_div_o lane
// PORTS
//  ref_clk_i      in   1        reference clock, only clock
//  glob_arst_ni   in   1        global reset, asynchronous, active-low
//  start_i        in   1        level; sampled in IDLE only
//  restart_i      in   1        level; sampled in DONE/ERROR only
//  cfg_ref_div_i  in   3x4      per-PLL ref divider, latched on leaving IDLE/SHUTDOWN
//  cfg_fb_div_i   in   3x12     per-PLL feedback divider, latched with cfg_ref_div_i
//  pll_locked_i   in   3        raw PLL lock flags (async), lane order e_core, p_core, sl
//  pll_ref_div_o  out  3x4      to clk_rst_gen pll_ref_div_*_i
//  pll_fb_div_o   out  3x12     to clk_rst_gen pll_fb_div_*_i
//  clk_en_o       out  NUM_DOM  to clk_rst_gen clk_en_*_i
//  arst_no        out  NUM_DOM  to clk_rst_gen arst_*_ni (active-low)
//  busy_o         out  1        high in CFG, WAIT_LOCK, SEQ, SHUTDOWN
//  done_o         out  1        high in DONE
//  err_o          out  1        high in ERROR
//  lock_lost_o    out  1        sticky: lock dropped while in SEQ/DONE; cleared on start_i/restart_i accept
// BEHAVIOUR
//  - Reset: state IDLE; clk_en_o=0, arst_no=0, dividers=DEF_*, busy/done/err/lock_lost=0. All outputs registered.
//  - pll_locked_i passes a 2-flop synchroniser (reset 0); all_lock = AND of synchronised lanes.
//  - IDLE: start_i=1 -> CFG next cycle; dividers take cfg_* at that same edge.
//  - CFG: hold SETTLE_CYC cycles, then WAIT_LOCK; timer cleared on entry.
//  - WAIT_LOCK: all_lock=1 -> SEQ (idx=0, phase EN). Else timer++; timer reaching LOCK_TIMEOUT
//    with all_lock=0 -> ERROR. Lock wins if both occur in the same cycle.
//  - SEQ, per idx: phase EN sets clk_en_o[idx]=1, waits STEP_DLY; phase REL sets arst_no[idx]=1,
//    waits STEP_DLY; idx++. After REL of idx NUM_DOM-1 -> DONE. Clock always runs STEP_DLY
//    cycles under reset before release; idx never wraps.
//  - DONE: outputs frozen (all clk_en_o=1, arst_no=1). restart_i=1 -> SHUTDOWN.
//  - all_lock falling in SEQ or DONE -> SHUTDOWN, lock_lost_o=1 (priority over restart_i).
//  - ERROR: clk_en_o/arst_no held 0. restart_i=1 -> SHUTDOWN.
//  - SHUTDOWN: entry edge drives arst_no=0 for all domains; clk_en_o unchanged for STEP_DLY
//    cycles, then all 0; then CFG with cfg_* relatched.
//  - start_i outside IDLE and restart_i outside DONE/ERROR are ignored.
//  - glob_arst_ni assertion mid-sequence: immediate return to reset values, no handshake.
// TESTING
//  (params SETTLE_CYC=4 LOCK_TIMEOUT=32 STEP_DLY=2)
//  1 cfg 2/40 per lane, start_i pulse, locks high at cycle 10 -> dividers=2/40 after 1 cycle;
//    clk_en_o[i] then arst_no[i] rise 2 cycles apart, i=0..4; done_o after 20 SEQ cycles.
//  2 locks never rise -> err_o=1 exactly 32 WAIT_LOCK cycles after CFG ends; clk_en_o=arst_no=0.
//  3 In DONE drop pll_locked_i[1] -> arst_no=0 within 3 cycles (sync+entry), clk_en_o=0 2 cycles
//    later, lock_lost_o=1, re-sequence completes once lock returns.
//  4 ERROR then restart_i with locks high -> SHUTDOWN, CFG, full sequence to done_o; lock_lost_o=0.
//  5 glob_arst_ni low while idx=2 in SEQ -> all outputs at reset values asynchronously; IDLE after.
//  6 start_i held during SEQ and restart_i pulsed during WAIT_LOCK -> no effect on timing of test 1.

Source files
------------

// File: rtl/clk_rst_seq.sv
// Power-up/restart sequencer for clk_rst_gen: programs the three PLL dividers, waits for lock,
// then enables clocks and releases resets one domain at a time (0=e_core 1=p_core 2=cl 3=sl 4=pl).
module clk_rst_seq #(
    parameter int unsigned NUM_DOM      = 5,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned STEP_DLY     = 8,
    parameter int unsigned DEF_REF_DIV  = 4,
    parameter int unsigned DEF_FB_DIV   = 48
) (
    input  logic               ref_clk_i,
    input  logic               glob_arst_ni,
    input  logic               start_i,
    input  logic               restart_i,
    input  logic [11:0]        cfg_ref_div_i,
    input  logic [35:0]        cfg_fb_div_i,
    input  logic [2:0]         pll_locked_i,
    output logic [11:0]        pll_ref_div_o,
    output logic [35:0]        pll_fb_div_o,
    output logic [NUM_DOM-1:0] clk_en_o,
    output logic [NUM_DOM-1:0] arst_no,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               lock_lost_o
);

    localparam int unsigned NUM_PLL = 3;
    localparam int unsigned REF_W   = 4;
    localparam int unsigned FB_W    = 12;
    localparam int unsigned IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int unsigned MAX_A   = (SETTLE_CYC > STEP_DLY) ? SETTLE_CYC : STEP_DLY;
    localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [NUM_PLL*REF_W-1:0] DEF_REF_VEC = {NUM_PLL{REF_W'(DEF_REF_DIV)}};
    localparam logic [NUM_PLL*FB_W-1:0]  DEF_FB_VEC  = {NUM_PLL{FB_W'(DEF_FB_DIV)}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT_LOCK,
        ST_SEQ,
        ST_DONE,
        ST_ERROR,
        ST_SHUTDOWN
    } state_t;

    typedef enum logic {
        PH_EN,
        PH_REL
    } phase_t;

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_PLL-1:0]   sync1_q, sync2_q;
    logic                 all_lock;
    logic                 latch_cfg;
    logic [11:0]          ref_div_d;
    logic [35:0]          fb_div_d;
    logic [NUM_DOM-1:0]   clk_en_d, arst_d;
    logic                 busy_d, done_d, err_d, lock_lost_d;

    // Two-flop synchroniser for the asynchronous PLL lock flags
    always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
        if (!glob_arst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
        end
    end

    assign all_lock = &sync2_q;

    // State and registered outputs
    always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
        if (!glob_arst_ni) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_EN;
            timer_q       <= '0;
            idx_q         <= '0;
            pll_ref_div_o <= DEF_REF_VEC;
            pll_fb_div_o  <= DEF_FB_VEC;
            clk_en_o      <= '0;
            arst_no       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            lock_lost_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            pll_ref_div_o <= ref_div_d;
            pll_fb_div_o  <= fb_div_d;
            clk_en_o      <= clk_en_d;
            arst_no       <= arst_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
            lock_lost_o   <= lock_lost_d;
        end
    end

    // Next-state and next-output logic; each output changes on the edge that enters its step
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        clk_en_d    = clk_en_o;
        arst_d      = arst_no;
        lock_lost_d = lock_lost_o;
        latch_cfg   = 1'b0;
        ref_div_d   = pll_ref_div_o;
        fb_div_d    = pll_fb_div_o;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_CFG;
                    timer_d     = '0;
                    latch_cfg   = 1'b1;
                    lock_lost_d = 1'b0;
                end
            end
            ST_CFG: begin
                if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout so a lock on the last cycle still wins
                if (all_lock) begin
                    state_d     = ST_SEQ;
                    phase_d     = PH_EN;
                    idx_d       = '0;
                    timer_d     = '0;
                    clk_en_d[0] = 1'b1;
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SEQ: begin
                if (!all_lock) begin
                    state_d     = ST_SHUTDOWN;
                    timer_d     = '0;
                    arst_d      = '0;
                    lock_lost_d = 1'b1;
                end else if (timer_q == TMR_W'(STEP_DLY - 1)) begin
                    timer_d = '0;
                    if (phase_q == PH_EN) begin
                        arst_d[idx_q] = 1'b1;
                        phase_d       = PH_REL;
                    end else if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d           = idx_q + IDX_W'(1);
                        clk_en_d[idx_d] = 1'b1;
                        phase_d         = PH_EN;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                if (!all_lock) begin
                    state_d     = ST_SHUTDOWN;
                    timer_d     = '0;
                    arst_d      = '0;
                    lock_lost_d = 1'b1;
                end else if (restart_i) begin
                    state_d     = ST_SHUTDOWN;
                    timer_d     = '0;
                    arst_d      = '0;
                    lock_lost_d = 1'b0;
                end
            end
            ST_ERROR: begin
                clk_en_d = '0;
                arst_d   = '0;
                if (restart_i) begin
                    state_d     = ST_SHUTDOWN;
                    timer_d     = '0;
                    lock_lost_d = 1'b0;
                end
            end
            ST_SHUTDOWN: begin
                // Clocks keep running under reset for STEP_DLY cycles before being gated
                if (timer_q == TMR_W'(STEP_DLY - 1)) begin
                    state_d   = ST_CFG;
                    timer_d   = '0;
                    clk_en_d  = '0;
                    latch_cfg = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (latch_cfg) begin
            ref_div_d = cfg_ref_div_i;
            fb_div_d  = cfg_fb_div_i;
        end

        busy_d = (state_d == ST_CFG) || (state_d == ST_WAIT_LOCK) ||
                 (state_d == ST_SEQ) || (state_d == ST_SHUTDOWN);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Randomized self-checking bench for clk_rst_seq; expectations come from a timeline model
// computed from the edge at which sequencing starts.
module tb_clk_rst_seq;

    localparam int ND     = 5;
    localparam int SETTLE = 4;
    localparam int LT     = 32;
    localparam int STEP   = 2;
    localparam int SEQ_LEN = 2 * STEP * ND;
    localparam logic [61:0] RST_VEC = {{3{4'd4}}, {3{12'd48}}, {(2 * ND + 4){1'b0}}};

    logic          clk;
    logic          glob_arst_ni;
    logic          start_i;
    logic          restart_i;
    logic [11:0]   cfg_ref_div_i;
    logic [35:0]   cfg_fb_div_i;
    logic [2:0]    pll_locked_i;
    logic [11:0]   pll_ref_div_o;
    logic [35:0]   pll_fb_div_o;
    logic [ND-1:0] clk_en_o;
    logic [ND-1:0] arst_no;
    logic          busy_o, done_o, err_o, lock_lost_o;

    logic [61:0]   all_out;
    logic [2*ND+3:0] flags;
    logic [11:0]   exp_ref;
    logic [35:0]   exp_fb;
    int            cyc;
    int            n_checks;
    int            n_pass;

    clk_rst_seq #(
        .NUM_DOM      (ND),
        .SETTLE_CYC   (SETTLE),
        .LOCK_TIMEOUT (LT),
        .STEP_DLY     (STEP),
        .DEF_REF_DIV  (4),
        .DEF_FB_DIV   (48)
    ) dut (
        .ref_clk_i     (clk),
        .glob_arst_ni  (glob_arst_ni),
        .start_i       (start_i),
        .restart_i     (restart_i),
        .cfg_ref_div_i (cfg_ref_div_i),
        .cfg_fb_div_i  (cfg_fb_div_i),
        .pll_locked_i  (pll_locked_i),
        .pll_ref_div_o (pll_ref_div_o),
        .pll_fb_div_o  (pll_fb_div_o),
        .clk_en_o      (clk_en_o),
        .arst_no       (arst_no),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .lock_lost_o   (lock_lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign all_out = {pll_ref_div_o, pll_fb_div_o, clk_en_o, arst_no, busy_o, done_o, err_o, lock_lost_o};
    assign flags   = {clk_en_o, arst_no, busy_o, done_o, err_o, lock_lost_o};

    // Expected {clk_en, arst_n, busy, done, err} at edge e for a sequence whose SEQ began at edge t:
    // domain i gets its clock 2*STEP*i cycles in and its reset release STEP cycles after that.
    function automatic logic [2*ND+2:0] model_out(input int e, input int t);
        logic [ND-1:0] ce, ar;
        int k;
        ce = '0;
        ar = '0;
        if (e < t) return {ce, ar, 3'b100};
        k = e - t;
        for (int i = 0; i < ND; i++) begin
            ce[i] = (k >= 2 * STEP * i);
            ar[i] = (k >= 2 * STEP * i + STEP);
        end
        return {ce, ar, (k < SEQ_LEN), (k >= SEQ_LEN), 1'b0};
    endfunction

    task automatic do_reset();
        start_i      = 1'b0;
        restart_i    = 1'b0;
        pll_locked_i = 3'b000;
        glob_arst_ni = 1'b0;
        repeat (2) @(negedge clk);
        glob_arst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (all_out !== RST_VEC) $display("FAIL reset_asserted got=%h exp=%h", all_out, RST_VEC);
        else n_pass++;
        pll_locked_i = 3'b111;
        glob_arst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            restart_i = (i == 1);
            @(negedge clk);
            n_checks++;
            if (all_out !== RST_VEC) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, all_out, RST_VEC);
            else n_pass++;
        end
        restart_i    = 1'b0;
        pll_locked_i = 3'b000;
    endtask

    // Full power-up; odd iterations hold start_i and pulse restart_i during WAIT_LOCK
    task automatic test_sequence(input int iters);
        int s, t, off;
        logic hold;
        for (int it = 0; it < iters; it++) begin
            do_reset();
            hold = (it % 2 == 1);
            off  = (it == 0) ? 9 : (it == 1) ? 34 : int'($urandom_range(0, 34));
            if (it == 0) begin
                cfg_ref_div_i = {3{4'd2}};
                cfg_fb_div_i  = {3{12'd40}};
            end else begin
                cfg_ref_div_i = 12'($urandom);
                cfg_fb_div_i  = {4'($urandom), 32'($urandom)};
            end
            exp_ref = cfg_ref_div_i;
            exp_fb  = cfg_fb_div_i;
            start_i = 1'b1;
            s = cyc + 1;
            t = (s + 2 + off > s + SETTLE + 1) ? s + 2 + off : s + SETTLE + 1;
            for (int e = s - 1; e <= t + SEQ_LEN + 2; e++) begin
                if (e >= s) begin
                    n_checks++;
                    if (flags !== {model_out(e, t), 1'b0})
                        $display("FAIL seq_flags it=%0d cyc=%0d got=%h exp=%h", it, e, flags, {model_out(e, t), 1'b0});
                    else n_pass++;
                    n_checks++;
                    if ({pll_ref_div_o, pll_fb_div_o} !== {exp_ref, exp_fb})
                        $display("FAIL seq_div it=%0d cyc=%0d got=%h exp=%h", it, e, {pll_ref_div_o, pll_fb_div_o}, {exp_ref, exp_fb});
                    else n_pass++;
                end
                if (e == s - 1 + off) pll_locked_i = 3'b111;
                if (e == s) begin
                    start_i       = hold;
                    cfg_ref_div_i = 12'($urandom);
                    cfg_fb_div_i  = {4'($urandom), 32'($urandom)};
                end
                if (hold && e == s + SETTLE) restart_i = 1'b1;
                if (e == s + SETTLE + 1) restart_i = 1'b0;
                @(negedge clk);
            end
            start_i = 1'b0;
        end
    endtask

    // From DONE: drop one lane's lock (with a simultaneous restart), then let it return
    task automatic test_lock_loss();
        int x, y, c, t, lane;
        logic [11:0] nref;
        logic [35:0] nfb;
        x    = cyc;
        lane = int'($urandom_range(0, 2));
        pll_locked_i[lane] = 1'b0;
        nref = 12'($urandom);
        nfb  = {4'($urandom), 32'($urandom)};
        cfg_ref_div_i = nref;
        cfg_fb_div_i  = nfb;
        y = x + 2 + int'($urandom_range(0, 10));
        c = x + 3 + STEP;
        t = (y + 3 > c + SETTLE + 1) ? y + 3 : c + SETTLE + 1;
        for (int e = x; e <= t + SEQ_LEN + 1; e++) begin
            if (e == c) begin
                exp_ref = nref;
                exp_fb  = nfb;
            end
            if (e >= x + 3) begin
                n_checks++;
                if (e < c) begin
                    if (flags !== {{ND{1'b1}}, {ND{1'b0}}, 4'b1001})
                        $display("FAIL loss_shutdown cyc=%0d got=%h exp=%h", e, flags, {{ND{1'b1}}, {ND{1'b0}}, 4'b1001});
                    else n_pass++;
                end else begin
                    if (flags !== {model_out(e, t), 1'b1})
                        $display("FAIL loss_reseq cyc=%0d got=%h exp=%h", e, flags, {model_out(e, t), 1'b1});
                    else n_pass++;
                end
                n_checks++;
                if ({pll_ref_div_o, pll_fb_div_o} !== {exp_ref, exp_fb})
                    $display("FAIL loss_div cyc=%0d got=%h exp=%h", e, {pll_ref_div_o, pll_fb_div_o}, {exp_ref, exp_fb});
                else n_pass++;
            end
            if (e == c) begin
                cfg_ref_div_i = 12'($urandom);
                cfg_fb_div_i  = {4'($urandom), 32'($urandom)};
            end
            restart_i = (e == x + 2);
            if (e == y) pll_locked_i = 3'b111;
            @(negedge clk);
        end
    endtask

    // From DONE: all locks drop for good, re-sequence times out; lock_lost stays set
    task automatic test_timeout();
        int x, c;
        logic [11:0] nref;
        logic [35:0] nfb;
        x = cyc;
        pll_locked_i = 3'b000;
        nref = 12'($urandom);
        nfb  = {4'($urandom), 32'($urandom)};
        cfg_ref_div_i = nref;
        cfg_fb_div_i  = nfb;
        c = x + 3 + STEP;
        for (int e = x; e <= c + SETTLE + LT + 4; e++) begin
            if (e == c) begin
                exp_ref = nref;
                exp_fb  = nfb;
            end
            if (e >= x + 3) begin
                n_checks++;
                if (e < c) begin
                    if (flags !== {{ND{1'b1}}, {ND{1'b0}}, 4'b1001})
                        $display("FAIL tmo_shutdown cyc=%0d got=%h", e, flags);
                    else n_pass++;
                end else if (e < c + SETTLE + LT) begin
                    if (flags !== {{(2 * ND){1'b0}}, 4'b1001})
                        $display("FAIL tmo_wait cyc=%0d got=%h exp=%h", e, flags, {{(2 * ND){1'b0}}, 4'b1001});
                    else n_pass++;
                end else begin
                    if (flags !== {{(2 * ND){1'b0}}, 4'b0011})
                        $display("FAIL tmo_error cyc=%0d got=%h exp=%h", e, flags, {{(2 * ND){1'b0}}, 4'b0011});
                    else n_pass++;
                end
                n_checks++;
                if ({pll_ref_div_o, pll_fb_div_o} !== {exp_ref, exp_fb})
                    $display("FAIL tmo_div cyc=%0d got=%h exp=%h", e, {pll_ref_div_o, pll_fb_div_o}, {exp_ref, exp_fb});
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    // From ERROR with locks restored: restart runs SHUTDOWN, CFG and a full sequence
    task automatic test_error_restart();
        int r, c, t;
        logic [11:0] nref;
        logic [35:0] nfb;
        pll_locked_i = 3'b111;
        repeat (4) @(negedge clk);
        r = cyc;
        restart_i = 1'b1;
        nref = 12'($urandom);
        nfb  = {4'($urandom), 32'($urandom)};
        cfg_ref_div_i = nref;
        cfg_fb_div_i  = nfb;
        c = r + 1 + STEP;
        t = c + SETTLE + 1;
        for (int e = r; e <= t + SEQ_LEN + 1; e++) begin
            if (e == c) begin
                exp_ref = nref;
                exp_fb  = nfb;
            end
            n_checks++;
            if (e == r) begin
                if (flags !== {{(2 * ND){1'b0}}, 4'b0011})
                    $display("FAIL err_hold cyc=%0d got=%h", e, flags);
                else n_pass++;
            end else if (e < c) begin
                if (flags !== {{(2 * ND){1'b0}}, 4'b1000})
                    $display("FAIL err_shutdown cyc=%0d got=%h exp=%h", e, flags, {{(2 * ND){1'b0}}, 4'b1000});
                else n_pass++;
            end else begin
                if (flags !== {model_out(e, t), 1'b0})
                    $display("FAIL err_reseq cyc=%0d got=%h exp=%h", e, flags, {model_out(e, t), 1'b0});
                else n_pass++;
            end
            if (e >= c) begin
                n_checks++;
                if ({pll_ref_div_o, pll_fb_div_o} !== {exp_ref, exp_fb})
                    $display("FAIL err_div cyc=%0d got=%h exp=%h", e, {pll_ref_div_o, pll_fb_div_o}, {exp_ref, exp_fb});
                else n_pass++;
            end
            if (e == r + 1) restart_i = 1'b0;
            @(negedge clk);
        end
    endtask

    // Global reset while domain 2 is enabled but still in reset, then a fresh start from IDLE
    task automatic test_async_reset();
        int s, t;
        do_reset();
        cfg_ref_div_i = 12'($urandom);
        cfg_fb_div_i  = {4'($urandom), 32'($urandom)};
        pll_locked_i  = 3'b111;
        start_i       = 1'b1;
        s = cyc + 1;
        t = s + SETTLE + 1;
        @(negedge clk);
        start_i = 1'b0;
        for (int g = 0; g < 100 && cyc < t + 2 * STEP * 2 + 1; g++) @(negedge clk);
        n_checks++;
        if (flags !== {model_out(cyc, t), 1'b0})
            $display("FAIL arst_pre cyc=%0d got=%h exp=%h", cyc, flags, {model_out(cyc, t), 1'b0});
        else n_pass++;
        glob_arst_ni = 1'b0;
        #1;
        n_checks++;
        if (all_out !== RST_VEC) $display("FAIL arst_immediate got=%h exp=%h", all_out, RST_VEC);
        else n_pass++;
        @(negedge clk);
        glob_arst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (all_out !== RST_VEC) $display("FAIL arst_idle cyc=%0d got=%h exp=%h", cyc, all_out, RST_VEC);
            else n_pass++;
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_checks++;
        if ({pll_ref_div_o, pll_fb_div_o, busy_o, done_o, err_o} !== {cfg_ref_div_i, cfg_fb_div_i, 3'b100})
            $display("FAIL arst_restart got=%h exp=%h", {pll_ref_div_o, pll_fb_div_o, busy_o, done_o, err_o},
                     {cfg_ref_div_i, cfg_fb_div_i, 3'b100});
        else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        glob_arst_ni  = 1'b0;
        start_i       = 1'b0;
        restart_i     = 1'b0;
        pll_locked_i  = 3'b000;
        cfg_ref_div_i = '0;
        cfg_fb_div_i  = '0;
        test_reset();
        test_sequence(6);
        test_lock_loss();
        test_timeout();
        test_error_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
